branch_resolve_queue: RTL

//  In-order queue between fetch and the 2-bit predictor's update port. Each fetched branch

---
 rtl/branch_resolve_queue_if.sv | 47 ++++
 rtl/branch_resolve_queue.sv | 82 ++++++++
 2 files changed

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: fetch/execute/predictor-update signals of the branch resolve queue.
// BRQ_STATS_EN adds the resolve/mispredict statistics outputs.
interface branch_resolve_queue_if #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 8
`ifdef BRQ_STATS_EN
    , parameter int CNT_W = 16
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic            alloc_valid;
    logic [PC_W-1:0] alloc_pc;
    logic            alloc_pred;
    logic            alloc_ready;
    logic            resolve_valid;
    logic            resolve_taken;
    logic            flush;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic            mispredict;
    logic [PC_W-1:0] mispredict_pc;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic            underflow_err;
`ifdef BRQ_STATS_EN
    logic [CNT_W-1:0] stat_resolved;
    logic [CNT_W-1:0] stat_mispredicted;
`endif
    modport master (
        output alloc_valid, alloc_pc, alloc_pred, resolve_valid, resolve_taken, flush,
        input  alloc_ready, upd_valid, upd_pc, upd_taken, mispredict, mispredict_pc,
               count, empty, full, underflow_err
`ifdef BRQ_STATS_EN
        , input stat_resolved, stat_mispredicted
`endif
    );
    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred, resolve_valid, resolve_taken, flush,
        output alloc_ready, upd_valid, upd_pc, upd_taken, mispredict, mispredict_pc,
               count, empty, full, underflow_err
`ifdef BRQ_STATS_EN
        , output stat_resolved, stat_mispredicted
`endif
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of predicted branches, resolved oldest-first into
// registered predictor updates; BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 8
) (
    input logic clk,
    input logic reset,
    branch_resolve_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [PC_W-1:0]  r_pc [DEPTH];
    logic [DEPTH-1:0] r_pred;
    logic [AW-1:0]    r_head, r_tail;
    logic [AW:0]      r_count;
    logic             r_upd_valid, r_upd_taken, r_mis, r_uf;
    logic [PC_W-1:0]  r_upd_pc, r_mis_pc;
    logic             w_empty, w_full, w_pop, w_mis, w_push, w_clear;
    assign w_empty = r_count == '0;
    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign w_pop   = bus.resolve_valid & ~w_empty;
    assign w_mis   = w_pop & (bus.resolve_taken != r_pred[r_head]);
    // wrong-path and flushed allocations never enter the queue
    assign w_clear = bus.flush | w_mis;
    assign w_push  = bus.alloc_valid & ~w_full & ~w_clear;
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail]   <= bus.alloc_pc;
            r_pred[r_tail] <= bus.alloc_pred;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_upd_valid <= 1'b0;
            r_upd_pc    <= '0;
            r_upd_taken <= 1'b0;
            r_mis       <= 1'b0;
            r_mis_pc    <= '0;
            r_uf        <= 1'b0;
        end else begin
            r_head      <= w_clear ? r_tail : r_head + AW'(w_pop);
            r_tail      <= r_tail + AW'(w_push);
            r_count     <= w_clear ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_upd_valid <= w_pop;
            r_mis       <= w_mis;
            r_uf        <= r_uf | (bus.resolve_valid & w_empty);
            if (w_pop) begin
                r_upd_pc    <= r_pc[r_head];
                r_upd_taken <= bus.resolve_taken;
            end
            if (w_mis) r_mis_pc <= r_pc[r_head];
        end
    end
    assign bus.alloc_ready   = ~w_full;
    assign bus.empty         = w_empty;
    assign bus.full          = w_full;
    assign bus.count         = r_count;
    assign bus.upd_valid     = r_upd_valid;
    assign bus.upd_pc        = r_upd_pc;
    assign bus.upd_taken     = r_upd_taken;
    assign bus.mispredict    = r_mis;
    assign bus.mispredict_pc = r_mis_pc;
    assign bus.underflow_err = r_uf;
`ifdef BRQ_STATS_EN
    logic [$bits(bus.stat_resolved)-1:0]     r_stat_res;
    logic [$bits(bus.stat_mispredicted)-1:0] r_stat_mis;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_res <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_pop && !(&r_stat_res)) r_stat_res <= r_stat_res + 1'b1;
            if (w_mis && !(&r_stat_mis)) r_stat_mis <= r_stat_mis + 1'b1;
        end
    end
    assign bus.stat_resolved     = r_stat_res;
    assign bus.stat_mispredicted = r_stat_mis;
`endif
endmodule
